acc_scheduler: RTL
==================

ACC_SCHEDULER -- requirements
Module: acc_scheduler

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; WIDTH, default 8, data width; IDW, default $clog2(NREQ), requester-ID width.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  NREQ  per-requester job valid.
REQ-005 req_data  input  NREQ*WIDTH  per-requester job operand; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 req_ready  output  NREQ  one-hot acceptance strobe.
REQ-007 rsp_valid  output  1  result valid.
REQ-008 rsp_ready  input  1  result consumer ready.
REQ-009 rsp_id  output  IDW  index of the requester whose job produced the result.
REQ-010 rsp_data  output  WIDTH  accumulator value after this job.
REQ-011 dout  output  WIDTH  running accumulator.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, ALIGN, ACC and RESP.
REQ-014 IDLE: if any req_valid is high, the round-robin winner SHALL get req_ready high combinationally that cycle; its req_data is latched into buffer, its index into rsp_id, and the next state is ALIGN.
REQ-015 req_ready SHALL be all-zero outside IDLE and when no request is pending.
REQ-016 Round-robin: the search SHALL start at last_grant+1 modulo NREQ; last_grant updates only on acceptance.
REQ-017 ALIGN: if buffer[1:0]!=0, buffer <= buffer+1 modulo 2^WIDTH and the FSM stays in ALIGN; otherwise it goes to ACC.
REQ-018 ACC: dout <= dout+buffer modulo 2^WIDTH, then go to RESP.
REQ-019 RESP: rsp_valid SHALL be 1, rsp_data==dout and rsp_id held; on rsp_valid&&rsp_ready the FSM returns to IDLE.
REQ-020 Latency: with acceptance in cycle 0 and k=(4-data[1:0])%4, rsp_valid SHALL first be high in cycle k+3.
REQ-021 Throughput: exactly one job in flight; no new acceptance before the RESP handshake completes.
REQ-022 Invariant: dout[1:0]==0 and rsp_data[1:0]==0 in every cycle after reset.
REQ-023 rsp_valid, rsp_id and rsp_data SHALL stay stable while rsp_valid&&!rsp_ready.

Reset
REQ-024 While reset_n is low, asynchronously: state=IDLE, dout=0, buffer=0, rsp_valid=0, rsp_id=0, last_grant=NREQ-1, req_ready=0, busy=0.
REQ-025 Reset asserted mid-job SHALL discard the job with no response; the first grant after reset goes to requester 0 if it is valid.

Configuration
REQ-026 Macro ACC_SCHEDULER_CLEAR_EN defined: input port clr (1 bit) SHALL exist; clr high in IDLE zeroes dout at the next edge, blocks any grant that cycle and is ignored in other states.
REQ-027 Macro ACC_SCHEDULER_CLEAR_EN undefined: the clr port and its logic SHALL be absent; dout clears only on reset.

Structure
REQ-028 Package acc_scheduler_pkg SHALL hold the FSM state enum, default NREQ/WIDTH constants and the 2-bit alignment mask constant.
REQ-029 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req vector, last_grant, enable; outputs one-hot grant and encoded index).

Verification
REQ-030 Reset, then req_valid[0] with data 0x05 and rsp_ready=1 -> accept in cycle 0; buffer 06, 07, 08; rsp_valid in cycle 6 with rsp_id=0 and rsp_data=0x08.
REQ-031 All four req_valid held high, each with data 0x04 -> grants in order 0,1,2,3,0; rsp_data 0x04, 0x08, 0x0C, 0x10; each rsp_valid 3 cycles after its acceptance.
REQ-032 dout=0xFC, then job 0xFF on req 2 -> one increment to 0x00, rsp_data=0xFC (no change); then job 0x08 -> rsp_data=0x04 (wrap).
REQ-033 rsp_ready held low for 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable, req_ready all-zero, busy=1; the FSM returns to IDLE the cycle after rsp_ready rises.
REQ-034 reset_n pulsed low during ALIGN -> immediate IDLE, dout=0, no rsp_valid; the next request from req 0 is granted first.
REQ-035 With ACC_SCHEDULER_CLEAR_EN, clr and req_valid[1] both high in IDLE -> dout=0 next cycle with no grant; the grant follows in the next cycle.

Source files
------------

// File: rtl/acc_scheduler_pkg.sv
// Shared types and constants for the accumulator scheduler.
package acc_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ALIGN,
    S_ACC,
    S_RESP
  } state_t;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/acc_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  logic w_found;
  int   w_j;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_j = (int'(i_last) + i) % NREQ;
      if (i_en && !w_found && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = IDW'(w_j);
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_scheduler.sv
// Round-robin job scheduler feeding a 4-aligned accumulator.
// Optional clr input enabled by ACC_SCHEDULER_CLEAR_EN.
module acc_scheduler
  import acc_scheduler_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
`ifdef ACC_SCHEDULER_CLEAR_EN
  input  logic               clr,
`endif
  output logic [IDW-1:0]     rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [WIDTH-1:0]   dout,
  output logic               busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] r_buf;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [IDW-1:0]   r_last;

  logic             w_en;
  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic [WIDTH-1:0] w_data;
  logic             w_unaligned;

`ifdef ACC_SCHEDULER_CLEAR_EN
  assign w_en = reset_n && (r_state == S_IDLE) && !clr;
`else
  assign w_en = reset_n && (r_state == S_IDLE);
`endif

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .i_req (req_valid),
    .i_last(r_last),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  assign w_data      = req_data[int'(w_idx)*WIDTH +: WIDTH];
  assign w_unaligned = (r_buf[1:0] & ALIGN_MASK) != 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dout      <= '0;
      r_buf       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_last      <= IDW'(NREQ-1);
    end else begin
      unique case (r_state)
        S_IDLE: begin
`ifdef ACC_SCHEDULER_CLEAR_EN
          if (clr) r_dout <= '0;
`endif
          if (|w_gnt) begin
            r_buf    <= w_data;
            r_rsp_id <= w_idx;
            r_last   <= w_idx;
            r_state  <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          if (w_unaligned) r_buf <= r_buf + WIDTH'(1);
          else             r_state <= S_ACC;
        end
        S_ACC: begin
          r_dout      <= r_dout + r_buf;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_dout;
  assign dout      = r_dout;
  assign busy      = (r_state != S_IDLE);

endmodule
